// File: rtl/p_cache_ctrl.sv
// p_cache_ctrl: direct-mapped read-only program cache between the PC/fetch stage and SDRAM.
// Latency: a hit returns instr one cycle after A is registered; a miss holds p_cache_miss through refill.
// Backpressure: p_cache_miss stalls the PC; mem_req is held until mem_ack; FILL waits on mem_valid.
// Ports:
//   clk, RST        clock, asynchronous active-high reset
//   A, flush        fetch word address; single-cycle invalidate-all pulse
//   instr           instruction word for the address presented one cycle earlier
//   p_cache_miss    high while instr is not valid (miss detected or refill running)
//   mem_req/addr    line fill request and line base address, held until mem_ack
//   mem_ack         one-cycle request accept
//   mem_valid/data  fill beats in ascending word order from offset 0
module p_cache_ctrl #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 3
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] A,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        p_cache_miss,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [15:0] mem_data
);

  localparam int TAG_BITS = 16 - INDEX_BITS - OFFSET_BITS;
  localparam int AW       = INDEX_BITS + OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << AW;

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESUME} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             addr_q;
  logic                    lookup_ok;
  logic                    flush_pend;
  logic [OFFSET_BITS-1:0]  beat_cnt;
  logic [LINES-1:0]        valid;
  logic [15-OFFSET_BITS:0] fill_line;   // {tag, index} of the line being refilled

  logic [15:0]             data_ram [WORDS];
  logic [TAG_BITS-1:0]     tag_ram  [LINES];

  logic [INDEX_BITS-1:0]   idx;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_BITS-1:0]     tag;
  logic [TAG_BITS-1:0]     fill_tag;
  logic                    hit;
  logic                    beat_wr;
  logic                    last_beat;
  logic [AW-1:0]           rd_addr;

  assign idx       = addr_q[AW-1:OFFSET_BITS];
  assign tag       = addr_q[15:AW];
  assign fill_idx  = fill_line[INDEX_BITS-1:0];
  assign fill_tag  = fill_line[15-OFFSET_BITS:INDEX_BITS];
  assign hit       = valid[idx] && (tag_ram[idx] == tag);
  assign beat_wr   = (state == FILL) && mem_valid;
  assign last_beat = beat_wr && (&beat_cnt);

  // RESUME re-reads the missed address so the word just written is on instr
  // in the first IDLE cycle; otherwise the RAM follows A for one-word-per-clock hits.
  assign rd_addr = (state == RESUME) ? addr_q[AW-1:0] : A[AW-1:0];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_addr     = '0;
    p_cache_miss = 1'b0;
    case (state)
      IDLE: begin
        // lookup_ok masks the first post-reset cycle, when addr_q is not yet a real fetch
        if (lookup_ok && !hit) begin
          p_cache_miss = 1'b1;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        p_cache_miss = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = {fill_line, {OFFSET_BITS{1'b0}}};
        if (mem_ack) state_nxt = FILL;
      end
      FILL: begin
        p_cache_miss = 1'b1;
        if (last_beat) state_nxt = RESUME;
      end
      RESUME: begin
        p_cache_miss = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      addr_q     <= '0;
      lookup_ok  <= 1'b0;
      flush_pend <= 1'b0;
      beat_cnt   <= '0;
      valid      <= '0;
      fill_line  <= '0;
    end else begin
      addr_q    <= A;
      lookup_ok <= 1'b1;
      // The refill target is captured once; later PC address changes cannot retarget it.
      if (state == IDLE && state_nxt == REQ) begin
        fill_line <= addr_q[15:OFFSET_BITS];
        beat_cnt  <= '0;
      end
      if (beat_wr) beat_cnt <= beat_cnt + 1'b1;
      // A flush seen at any point during FILL (including the last beat) keeps
      // the incoming line invalid, so the re-lookup refetches it.
      if (flush)
        valid <= '0;
      else if (last_beat && !flush_pend)
        valid[fill_idx] <= 1'b1;
      if (last_beat)
        flush_pend <= 1'b0;
      else if (flush && state == FILL)
        flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr)   data_ram[{fill_idx, beat_cnt}] <= mem_data;
    if (last_beat) tag_ram[fill_idx] <= fill_tag;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) instr <= '0;
    else     instr <= data_ram[rd_addr];
  end

endmodule

// File: doc/p_cache_ctrl.md
# p_cache_ctrl

Direct-mapped, read-only program cache controller that answers the program counter's fetch address stream and returns 16-bit instruction words. It sits between the PC/fetch stage and the SDRAM arbiter. It asserts `p_cache_miss` for the whole duration of a line refill; the PC holds and re-presents the missed address while this signal is high. Line fills use a request/acknowledge plus beat-valid burst interface toward SDRAM.

## Interface
- `INDEX_BITS`, default 6: line index width (64 lines).
- `OFFSET_BITS`, default 3: word-in-line width (8 words per line).
- Tag width is 16 − `INDEX_BITS` − `OFFSET_BITS` (default 7).

Ports:
- `clk`  in  1  clock
- `RST`  in  1  reset; asynchronous, active-high
- `A`  in  16  fetch word address from the PC
- `flush`  in  1  single-cycle pulse; invalidate all lines
- `instr`  out  16  instruction word for the address presented one cycle earlier
- `p_cache_miss`  out  1  high while `instr` is not valid and a refill is pending or in progress
- `mem_req`  out  1  line fill request, held until acknowledged
- `mem_addr`  out  16  line base address: `{tag, index, OFFSET_BITS'b0}`
- `mem_ack`  in  1  one-cycle pulse accepting the request
- `mem_valid`  in  1  one data beat present on `mem_data`
- `mem_data`  in  16  fill data, in ascending word order starting at offset 0

## Operation
- Storage:
  - Data RAM of 2^(`INDEX_BITS`+`OFFSET_BITS`) × 16, synchronous read.
  - Tag RAM of 2^`INDEX_BITS` × tag width.
  - `valid` register vector of 2^`INDEX_BITS` bits, reset to all zero.
- Lookup:
  - `A` is registered into `addr_q` on every edge.
  - The data RAM is read at `A` on the same edge.
  - `hit` = `valid[idx(addr_q)]` and (`tag_ram[idx]` == `tag(addr_q)`).
- FSM states and transitions:
  - IDLE → REQ when `lookup_ok` and not `hit`. `lookup_ok` is a register cleared by reset and set 1 on the first edge after reset.
  - REQ: `mem_req`=1 and `mem_addr` = line base of `addr_q`. REQ → FILL on `mem_ack`.
  - FILL: each `mem_valid` beat writes `mem_data` to data RAM at `{idx, beat_cnt}` and increments `beat_cnt`. On beat `LINE_WORDS`−1, write the tag, set `valid[idx]` (unless `flush_pend`), and go to RESUME.
  - RESUME: one cycle in which the data RAM re-reads `addr_q`. RESUME → IDLE.
- `p_cache_miss` = (IDLE and `lookup_ok` and not `hit`) or (state ≠ IDLE). It is combinational from the state and the registered lookup.
- While `p_cache_miss` is high, `addr_q` is still sampled from `A`. The fill line and index are latched into `fill_addr` on the IDLE→REQ edge and are not affected by later changes on `A`.
- `beat_cnt` is `OFFSET_BITS` wide and reset to 0 on entry to REQ. Gaps between beats are allowed; FILL waits indefinitely.
- Flush:
  - In IDLE, REQ or RESUME, clear all `valid` bits on the next edge.
  - In FILL, clear all `valid` bits and set `flush_pend`. On completion the line is not marked valid and `flush_pend` clears. The re-lookup after RESUME then misses and refetches.
  - Flush coincident with the final beat is treated as flush in FILL.
- Reset values:
  - State IDLE; `valid` all 0; `lookup_ok`, `flush_pend`, `beat_cnt` = 0.
  - Outputs: `mem_req`=0, `mem_addr`=0, `instr`=0, `p_cache_miss`=0.
  - RAM contents are undefined.
- Reset mid-fill: abandon immediately with `mem_req` low. The SDRAM side must discard the burst on `RST`.

## Timing
- Hit latency: `A` presented at edge N, `instr` valid after edge N+1. Throughput is one word per clock.
- Miss detect: `p_cache_miss` rises combinationally in the cycle after the missing address is registered.
- `mem_req` rises one cycle after the miss is detected.
- Miss penalty: 1 (REQ minimum) + ack wait + `LINE_WORDS` beats + 1 (RESUME) + 1 (re-lookup) cycles.
  - With immediate ack and back-to-back beats: 11 cycles from miss assertion to the first hit cycle.
- `p_cache_miss` falls in the first IDLE cycle after RESUME. In that cycle `instr` holds the word for `addr_q` and `hit`=1.
- `mem_req` is low in every state except REQ. `mem_ack` outside REQ is ignored. `mem_valid` outside FILL is ignored.

## Test plan
- Cold start: release `RST`, hold `A`=0x0000 → `p_cache_miss`=1; `mem_addr`=0x0000; 8 beats 0xA000..0xA007 → `instr`=0xA000 and `p_cache_miss`=0 exactly 11 cycles after miss assertion.
- Sequential hits: after the fill, step `A` 0x0001..0x0007 one per clock → `instr`=0xA001..0xA007 on consecutive cycles with `p_cache_miss` low; `A`=0x0008 → new miss with `mem_addr`=0x0008.
- Conflict eviction: fill 0x0010 and then 0x0410 (same index, different tag) → 0x0010 misses again; `mem_addr`=0x0010.
- Stalled fill: `mem_ack` delayed 5 cycles, beats separated by 3-cycle gaps → `mem_req` held until ack; `p_cache_miss` stays high throughout; data is correct.
- Flush in FILL at beat 4 → fill completes and RESUME is entered; the next IDLE lookup misses; a second request is issued for the same line base.
- Reset mid-FILL at beat 3 → `mem_req`=0 and `p_cache_miss`=0 at the reset edge; after release, address 0 misses and refills.
